// File: rtl/rs_bank_pkg.sv
// Shared types for the reservation-station bank: tag/operand widths, entry layout
// and the CDB wakeup helper used by both stored and freshly dispatched operands.
package rs_bank_pkg;

    localparam int ROB_TAG_LEN = 5;
    localparam int XLEN        = 32;
    localparam int OPC_W       = 6;

    typedef struct packed {
        logic                   ready;
        logic [XLEN-1:0]        value;
        logic [ROB_TAG_LEN-1:0] tag;
    } rs_src_t;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [OPC_W-1:0]       opcode;
        rs_src_t                rs1;
        rs_src_t                rs2;
    } rs_entry_t;

    // An operand that is already ready keeps its value even if its stale tag matches.
    function automatic rs_src_t wake_src(input rs_src_t src,
                                         input logic cdb_valid,
                                         input logic [ROB_TAG_LEN-1:0] cdb_tag,
                                         input logic [XLEN-1:0] cdb_value);
        rs_src_t res;
        res = src;
        if (cdb_valid && !src.ready && (src.tag == cdb_tag)) begin
            res.ready = 1'b1;
            res.value = cdb_value;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest (largest age) entry that is valid with both operands ready.
// Ages of valid entries are unique, so at most one grant bit is set.
module rs_oldest_select #(
    parameter int N     = 4,
    parameter int AGE_W = 2
) (
    input  logic [N-1:0]            valid,
    input  logic [N-1:0]            ready,
    input  logic [N-1:0][AGE_W-1:0] age,
    output logic [N-1:0]            grant,
    output logic                    any_ready
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        grant     = '0;
        any_ready = 1'b0;
        best_age  = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && ready[i] && (!any_ready || (age[i] > best_age))) begin
                grant     = '0;
                grant[i]  = 1'b1;
                best_age  = age[i];
                any_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank for one FU class: allocates dispatched instructions, wakes
// operands from the CDB and presents the oldest ready entry to the issue unit.
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           dispatch_valid,
    input  logic [ROB_TAG_LEN-1:0]         dispatch_rob_tag,
    input  logic [OPC_W-1:0]               dispatch_opcode,
    input  logic                           dispatch_rs1_ready,
    input  logic [XLEN-1:0]                dispatch_rs1_value,
    input  logic [ROB_TAG_LEN-1:0]         dispatch_rs1_tag,
    input  logic                           dispatch_rs2_ready,
    input  logic [XLEN-1:0]                dispatch_rs2_value,
    input  logic [ROB_TAG_LEN-1:0]         dispatch_rs2_tag,
    input  logic                           cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]         cdb_tag,
    input  logic [XLEN-1:0]                cdb_value,
    input  logic                           issue_grant,
    output logic                           instr_ready,
    output logic [ROB_TAG_LEN-1:0]         out_ROB_tag,
    output logic [OPC_W-1:0]               out_opcode,
    output logic [XLEN-1:0]                out_rs1_value,
    output logic [XLEN-1:0]                out_rs2_value,
    output logic                           full,
    output logic [$clog2(NUM_ENTRIES):0]   free_count
);

    localparam int AGE_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = AGE_W + 1;

    rs_entry_t                        ent_q [NUM_ENTRIES];
    rs_entry_t                        ent_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][AGE_W-1:0] age_q, age_d;

    logic [NUM_ENTRIES-1:0] valid_vec, ready_vec, sel_oh, alloc_oh;
    logic                   any_ready, issue_fire, alloc, free_found;
    logic [AGE_W-1:0]       free_age;
    logic [CNT_W-1:0]       used_cnt;
    rs_entry_t              disp_ent;

    always_comb begin
        valid_vec  = '0;
        ready_vec  = '0;
        alloc_oh   = '0;
        used_cnt   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].rs1.ready && ent_q[i].rs2.ready;
            used_cnt     = used_cnt + CNT_W'(ent_q[i].valid);
            if (!ent_q[i].valid && !free_found) begin
                alloc_oh[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    assign free_count = CNT_W'(NUM_ENTRIES) - used_cnt;
    assign full       = (free_count == '0);

    rs_oldest_select #(
        .N     (NUM_ENTRIES),
        .AGE_W (AGE_W)
    ) u_select (
        .valid     (valid_vec),
        .ready     (ready_vec),
        .age       (age_q),
        .grant     (sel_oh),
        .any_ready (any_ready)
    );

    always_comb begin
        out_ROB_tag   = '0;
        out_opcode    = '0;
        out_rs1_value = '0;
        out_rs2_value = '0;
        free_age      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh[i]) begin
                out_ROB_tag   = ent_q[i].rob_tag;
                out_opcode    = ent_q[i].opcode;
                out_rs1_value = ent_q[i].rs1.value;
                out_rs2_value = ent_q[i].rs2.value;
                free_age      = age_q[i];
            end
        end
    end

    assign instr_ready = any_ready;
    assign issue_fire  = issue_grant && any_ready;
    // full reflects current occupancy, so a same-cycle grant never admits a dispatch
    assign alloc       = dispatch_valid && !full;

    always_comb begin
        disp_ent         = '0;
        disp_ent.valid   = 1'b1;
        disp_ent.rob_tag = dispatch_rob_tag;
        disp_ent.opcode  = dispatch_opcode;
        disp_ent.rs1     = wake_src(rs_src_t'{dispatch_rs1_ready, dispatch_rs1_value, dispatch_rs1_tag},
                                    cdb_valid, cdb_tag, cdb_value);
        disp_ent.rs2     = wake_src(rs_src_t'{dispatch_rs2_ready, dispatch_rs2_value, dispatch_rs2_tag},
                                    cdb_valid, cdb_tag, cdb_value);
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            age_d[i] = age_q[i];
            if (flush) begin
                ent_d[i].valid = 1'b0;
                age_d[i]       = '0;
            end else if (alloc && alloc_oh[i]) begin
                ent_d[i] = disp_ent;
                age_d[i] = '0;
            end else if (ent_q[i].valid) begin
                if (issue_fire && sel_oh[i]) begin
                    ent_d[i].valid = 1'b0;
                    age_d[i]       = '0;
                end else begin
                    ent_d[i].rs1 = wake_src(ent_q[i].rs1, cdb_valid, cdb_tag, cdb_value);
                    ent_d[i].rs2 = wake_src(ent_q[i].rs2, cdb_valid, cdb_tag, cdb_value);
                    // older than everything new, closes the gap left by the freed entry
                    age_d[i] = age_q[i] + AGE_W'(alloc)
                             - AGE_W'(issue_fire && (age_q[i] > free_age));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            age_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            age_q <= age_d;
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// Directed vector bench for rs_bank: one table of per-cycle stimulus with expected
// post-edge outputs, plus a hand-written asynchronous-reset sequence.
module tb_rs_bank;
    import rs_bank_pkg::*;

    localparam int N     = 4;
    localparam int CNT_W = $clog2(N) + 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic                   dispatch_valid;
    logic [ROB_TAG_LEN-1:0] dispatch_rob_tag;
    logic [OPC_W-1:0]       dispatch_opcode;
    logic                   dispatch_rs1_ready;
    logic [XLEN-1:0]        dispatch_rs1_value;
    logic [ROB_TAG_LEN-1:0] dispatch_rs1_tag;
    logic                   dispatch_rs2_ready;
    logic [XLEN-1:0]        dispatch_rs2_value;
    logic [ROB_TAG_LEN-1:0] dispatch_rs2_tag;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic                   issue_grant;
    logic                   instr_ready;
    logic [ROB_TAG_LEN-1:0] out_ROB_tag;
    logic [OPC_W-1:0]       out_opcode;
    logic [XLEN-1:0]        out_rs1_value;
    logic [XLEN-1:0]        out_rs2_value;
    logic                   full;
    logic [CNT_W-1:0]       free_count;

    always #5 clk = ~clk;

    rs_bank #(.NUM_ENTRIES(N)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_rob_tag   (dispatch_rob_tag),
        .dispatch_opcode    (dispatch_opcode),
        .dispatch_rs1_ready (dispatch_rs1_ready),
        .dispatch_rs1_value (dispatch_rs1_value),
        .dispatch_rs1_tag   (dispatch_rs1_tag),
        .dispatch_rs2_ready (dispatch_rs2_ready),
        .dispatch_rs2_value (dispatch_rs2_value),
        .dispatch_rs2_tag   (dispatch_rs2_tag),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .cdb_value          (cdb_value),
        .issue_grant        (issue_grant),
        .instr_ready        (instr_ready),
        .out_ROB_tag        (out_ROB_tag),
        .out_opcode         (out_opcode),
        .out_rs1_value      (out_rs1_value),
        .out_rs2_value      (out_rs2_value),
        .full               (full),
        .free_count         (free_count)
    );

    // stimulus for one cycle | outputs expected just after that cycle's edge
    typedef struct {
        int fl, dv, tag, r1r, r1v, r1t, r2r, r2v, r2t, cv, ctag, cval, gr;
        int rdy, etag, e1, e2, efull, efc;
    } vec_t;

    vec_t tbl[$];
    vec_t idle_v;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int rdy, input int etag, input int e1,
                         input int e2, input int efull, input int efc);
        logic [OPC_W-1:0] eop;
        eop = (rdy != 0) ? OPC_W'(etag + 32) : '0;
        n_vec++;
        if (instr_ready !== 1'(rdy) || out_ROB_tag !== ROB_TAG_LEN'(etag) ||
            out_opcode !== eop || out_rs1_value !== XLEN'(e1) ||
            out_rs2_value !== XLEN'(e2) || full !== 1'(efull) ||
            free_count !== CNT_W'(efc)) begin
            n_bad++;
            $display("FAIL %s: got rdy=%0d tag=%0h op=%0h v1=%0h v2=%0h full=%0d free=%0d; want rdy=%0d tag=%0h op=%0h v1=%0h v2=%0h full=%0d free=%0d",
                     name, instr_ready, out_ROB_tag, out_opcode, out_rs1_value, out_rs2_value,
                     full, free_count, rdy, etag, eop, e1, e2, efull, efc);
        end
    endtask

    task automatic drive(input vec_t v);
        flush              = 1'(v.fl);
        dispatch_valid     = 1'(v.dv);
        dispatch_rob_tag   = ROB_TAG_LEN'(v.tag);
        dispatch_opcode    = OPC_W'(v.tag + 32);
        dispatch_rs1_ready = 1'(v.r1r);
        dispatch_rs1_value = XLEN'(v.r1v);
        dispatch_rs1_tag   = ROB_TAG_LEN'(v.r1t);
        dispatch_rs2_ready = 1'(v.r2r);
        dispatch_rs2_value = XLEN'(v.r2v);
        dispatch_rs2_tag   = ROB_TAG_LEN'(v.r2t);
        cdb_valid          = 1'(v.cv);
        cdb_tag            = ROB_TAG_LEN'(v.ctag);
        cdb_value          = XLEN'(v.cval);
        issue_grant        = 1'(v.gr);
    endtask

    task automatic apply(input vec_t v, input string name);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v.rdy, v.etag, v.e1, v.e2, v.efull, v.efc);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0;
        drive(idle_v);

        //   fl dv tag   r1r r1v   r1t r2r r2v   r2t cv ctag cval  gr | rdy etag  e1    e2  full fc
        // single ready instruction, then issue
        add('{0, 1, 5,    1, 3,    0,  1, 4,    0,  0, 0,   0,    0,   1, 5,    3,    4,    0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});
        // rs1 waits on tag 2, CDB two cycles later
        add('{0, 1, 7,    0, 'h33, 2,  1, 1,    0,  0, 0,   0,    0,   0, 0,    0,    0,    0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    0,   0, 0,    0,    0,    0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  1, 2,   'h55, 0,   1, 7,    'h55, 1,    0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});
        // three in order, issued back-to-back oldest first
        add('{0, 1, 1,    1, 'h11, 0,  1, 'h12, 0,  0, 0,   0,    0,   1, 1,    'h11, 'h12, 0, 3});
        add('{0, 1, 2,    1, 'h21, 0,  1, 'h22, 0,  0, 0,   0,    0,   1, 1,    'h11, 'h12, 0, 2});
        add('{0, 1, 3,    1, 'h31, 0,  1, 'h32, 0,  0, 0,   0,    0,   1, 1,    'h11, 'h12, 0, 1});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   1, 2,    'h21, 'h22, 0, 2});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   1, 3,    'h31, 'h32, 0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});
        // older entry waiting, younger ready one goes first
        add('{0, 1, 4,    0, 'h44, 9,  1, 'h42, 0,  0, 0,   0,    0,   0, 0,    0,    0,    0, 3});
        add('{0, 1, 6,    1, 'h61, 0,  1, 'h62, 0,  0, 0,   0,    0,   1, 6,    'h61, 'h62, 0, 2});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  1, 9,   'h99, 1,   1, 4,    'h99, 'h42, 0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});
        // oldest lives at a higher index than a younger ready entry
        add('{0, 1, 'hA,  1, 1,    0,  1, 2,    0,  0, 0,   0,    0,   1, 'hA,  1,    2,    0, 3});
        add('{0, 1, 'hB,  0, 0,    'hC,1, 3,    0,  0, 0,   0,    0,   1, 'hA,  1,    2,    0, 2});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 3});
        add('{0, 1, 'hD,  1, 5,    0,  1, 6,    0,  0, 0,   0,    0,   1, 'hD,  5,    6,    0, 2});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  1, 'hC, 'h77, 0,   1, 'hB,  'h77, 3,    0, 2});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   1, 'hD,  5,    6,    0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});
        // fill, then a dispatch alongside a grant is dropped
        add('{0, 1, 'h10, 1, 'h10, 0,  1, 'h11, 0,  0, 0,   0,    0,   1, 'h10, 'h10, 'h11, 0, 3});
        add('{0, 1, 'h11, 1, 'h11, 0,  1, 'h12, 0,  0, 0,   0,    0,   1, 'h10, 'h10, 'h11, 0, 2});
        add('{0, 1, 'h12, 1, 'h12, 0,  1, 'h13, 0,  0, 0,   0,    0,   1, 'h10, 'h10, 'h11, 0, 1});
        add('{0, 1, 'h13, 1, 'h13, 0,  1, 'h14, 0,  0, 0,   0,    0,   1, 'h10, 'h10, 'h11, 1, 0});
        add('{0, 1, 'h14, 1, 'h14, 0,  1, 'h15, 0,  0, 0,   0,    1,   1, 'h11, 'h11, 'h12, 0, 1});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   1, 'h12, 'h12, 'h13, 0, 2});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   1, 'h13, 'h13, 'h14, 0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});
        // ready operand with a matching stale tag is not overwritten
        add('{0, 1, 'h1A, 1, 5,    4,  1, 6,    0,  1, 4,   'hEE, 0,   1, 'h1A, 5,    6,    0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  1, 4,   'hEE, 0,   1, 'h1A, 5,    6,    0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});
        // same-cycle bypass, then flush beats dispatch/grant/wakeup
        add('{0, 1, 8,    1, 'h81, 0,  0, 'h11, 3,  1, 3,   'hAA, 0,   1, 8,    'h81, 'hAA, 0, 3});
        add('{1, 1, 'hF,  1, 1,    0,  1, 2,    0,  1, 3,   'hBB, 1,   0, 0,    0,    0,    0, 4});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    0,   0, 0,    0,    0,    0, 4});
        add('{0, 1, 2,    1, 'h2A, 0,  1, 'h2B, 0,  0, 0,   0,    0,   1, 2,    'h2A, 'h2B, 0, 3});
        add('{0, 0, 0,    0, 0,    0,  0, 0,    0,  0, 0,   0,    1,   0, 0,    0,    0,    0, 4});

        repeat (2) @(posedge clk);
        #1;
        check("in_reset", 0, 0, 0, 0, 0, 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 0, 0, 0, 0, 0, 4);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset in the middle of a cycle with a grant pending
        v = '{0, 1, 3, 1, 7, 0, 1, 8, 0, 0, 0, 0, 0,   1, 3, 7, 8, 0, 3};
        apply(v, "pre_rst_a");
        v = '{0, 1, 4, 1, 9, 0, 1, 10, 0, 0, 0, 0, 0,  1, 3, 7, 8, 0, 2};
        apply(v, "pre_rst_b");
        drive(idle_v);
        issue_grant = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 4);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        issue_grant = 1'b0;
        check("reset_grant_lost", 0, 0, 0, 0, 0, 4);
        v = '{0, 1, 5, 1, 'h50, 0, 1, 'h51, 0, 0, 0, 0, 0,  1, 5, 'h50, 'h51, 0, 3};
        apply(v, "post_rst_disp");
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0, 0, 4};
        apply(v, "post_rst_issue");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Reservation-station bank for one functional-unit class (integer, branch, load/store or mult).
- Sits between dispatch and the issue unit.
- Holds renamed instructions and wakes source operands from the CDB.
- Presents the oldest fully-ready entry to the issue unit as instr_ready plus its ROB tag, and frees that entry when the issue unit grants it.
- Four instances, one per FU class, drive the issue unit's instr_ready[3:0] and in_ROB_tag[3:0].

Parameters:
- NUM_ENTRIES, 4, number of RS entries; power of two, at least 2.
- OPC_W, 6, opcode/control field width.
- XLEN, 32, operand data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  mispredict squash; clears all entries
- dispatch_valid  in  1  new instruction this cycle
- dispatch_rob_tag  in  `ROB_TAG_LEN  destination ROB tag
- dispatch_opcode  in  OPC_W  operation
- dispatch_rs1_ready  in  1  rs1 value is valid
- dispatch_rs1_value  in  XLEN  rs1 value
- dispatch_rs1_tag  in  `ROB_TAG_LEN  producer tag if rs1 is not ready
- dispatch_rs2_ready, dispatch_rs2_value, dispatch_rs2_tag  in  1/XLEN/`ROB_TAG_LEN  same as rs1
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  `ROB_TAG_LEN  broadcasting ROB tag
- cdb_value  in  XLEN  broadcast result
- issue_grant  in  1  issue unit accepted the presented entry
- instr_ready  out  1  at least one entry has both operands ready
- out_ROB_tag  out  `ROB_TAG_LEN  ROB tag of the oldest ready entry
- out_opcode  out  OPC_W  opcode of the presented entry
- out_rs1_value, out_rs2_value  out  XLEN  operands of the presented entry
- full  out  1  no free entry
- free_count  out  $clog2(NUM_ENTRIES)+1  number of free entries

Behaviour:
- Per-entry state: valid, rob_tag, opcode, rs1/rs2 {ready, value, tag}, age ($clog2(NUM_ENTRIES) bits).
- All state is registered. Outputs are combinational from registered state only; no input-to-output combinational path.
- Reset (reset=0, async): all valid=0 and all ages=0. Outputs are then instr_ready=0, out_*=0, full=0, free_count=NUM_ENTRIES.
- Allocation:
  - On dispatch_valid && !full, write the lowest-index free entry at the clock edge.
  - Dispatch while full is dropped silently; dispatch must stall on full.
  - full is computed from current state. A grant in the same cycle does not unblock a dispatch in that cycle.
- Wakeup:
  - cdb_valid && cdb_tag==entry.rsX_tag && !entry.rsX_ready sets ready=1 and value=cdb_value at the edge.
  - Same-cycle bypass: a dispatched operand with ready=0 whose tag matches the same-cycle CDB is written as ready, with value=cdb_value.
  - A woken entry becomes visible on instr_ready the cycle after the CDB broadcast.
- Age:
  - Allocated entry gets age 0. All other valid entries increment their age.
  - On free of an entry with age a, every valid entry with age > a decrements.
  - Simultaneous alloc and free: new_age = age + 1 - (age > a_free).
  - Valid ages are always unique, in the range 0..count-1.
- Select: among entries with valid && rs1_ready && rs2_ready, present the one with the largest age (oldest). If none is ready, instr_ready=0 and out_* = 0.
- Issue:
  - issue_grant && instr_ready frees the presented entry at the edge.
  - issue_grant while instr_ready=0 is ignored.
  - The next-oldest ready entry is presented the following cycle, allowing one issue per cycle back-to-back.
- Flush:
  - Clears all valid bits at the edge.
  - Takes priority over dispatch, grant and wakeup in the same cycle.
  - Next cycle: instr_ready=0, free_count=NUM_ENTRIES.
- Reset asserted mid-operation: state clears immediately; the in-flight grant is lost.
- free_count = NUM_ENTRIES minus the popcount of valid bits. full = (free_count == 0).

Decomposition:
- Entries to sys_defs.svh: `ROB_TAG_LEN (existing), XLEN, and a typedef rs_entry_t holding the per-entry fields.
- One sub-module, rs_oldest_select: combinational. Takes valid and ready vectors plus ages; outputs a one-hot grant and an any_ready flag.

Test Plan:
- Reset, then dispatch tag 5, both operands ready (rs1=3, rs2=4) -> next cycle instr_ready=1, out_ROB_tag=5, out_rs1_value=3, out_rs2_value=4; grant -> following cycle instr_ready=0, free_count=4.
- Dispatch tag 7 with rs1 waiting on tag 2; CDB tag 2, value 0x55 two cycles later -> instr_ready rises the cycle after the broadcast, out_rs1_value=0x55.
- Dispatch tags 1, 2, 3 in order, all ready, grant held high -> out_ROB_tag presents 1, 2, 3 on consecutive cycles; instr_ready drops after tag 3 issues.
- Dispatch tag 4 waiting on tag 9, then tag 6 ready -> tag 6 presented first; CDB tag 9 -> after tag 6 issues, tag 4 presented.
- Fill 4 entries -> full=1. A 5th dispatch together with a grant -> the 5th is dropped; free_count=1 next cycle.
- Dispatch with rs2 tag 3 while the same cycle has CDB tag 3, value 0xAA -> bypass: instr_ready=1 next cycle, out_rs2_value=0xAA. Then flush together with a dispatch -> free_count=4, instr_ready=0.
